// File: rtl/axi_lite_regs.sv
// AXI-Lite slave exposing NUM_REGS byte-writable registers, with per-register write pulses.
// Write and read channels run independently; AW and W may arrive in any order.
module axi_lite_regs #(
  parameter int                             ADDR_WIDTH = 32,
  parameter int                             DATA_WIDTH = 32,
  parameter int                             NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR  = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [DATA_WIDTH-1:0]          w_data_i,
  input  logic [DATA_WIDTH/8-1:0]        w_strb_i,
  input  logic                           w_valid_i,
  output logic                           w_ready_o,
  output logic [1:0]                     b_resp_o,
  output logic                           b_valid_o,
  input  logic                           b_ready_i,
  input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  output logic [DATA_WIDTH-1:0]          r_data_o,
  output logic [1:0]                     r_resp_o,
  output logic                           r_valid_o,
  input  logic                           r_ready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} wr_state_e;

  // The borrow bit of the widened subtraction flags addresses below BASE_ADDR.
  function automatic logic in_range_f(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, addr} - {1'b0, BASE_ADDR};
    return !diff[ADDR_WIDTH] && ((diff[ADDR_WIDTH-1:0] >> ADDR_LSB) < NUM_REGS_A);
  endfunction

  function automatic logic [IDX_W-1:0] index_f(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> ADDR_LSB);
  endfunction

  wr_state_e               wr_state_q;
  logic                    alive_q;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic [1:0]              b_resp_q;
  logic                    r_valid_q;
  logic [DATA_WIDTH-1:0]   r_data_q;
  logic [1:0]              r_resp_q;

  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0]   cmt_addr;
  logic [DATA_WIDTH-1:0]   cmt_data;
  logic [STRB_W-1:0]       cmt_strb;
  logic                    cmt_in_range, rd_in_range;
  logic [IDX_W-1:0]        cmt_idx, rd_idx;

  // Readies stay low until the first clock edge after reset releases.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) alive_q <= 1'b0;
    else         alive_q <= 1'b1;
  end

  assign aw_ready_o = alive_q && (wr_state_q == IDLE || wr_state_q == HAVE_W);
  assign w_ready_o  = alive_q && (wr_state_q == IDLE || wr_state_q == HAVE_AW);
  assign b_valid_o  = (wr_state_q == RESP);
  assign b_resp_o   = b_resp_q;

  assign aw_hs  = aw_valid_i && aw_ready_o;
  assign w_hs   = w_valid_i && w_ready_o;
  assign commit = ((wr_state_q == HAVE_AW) || aw_hs) && ((wr_state_q == HAVE_W) || w_hs) && !b_valid_o;

  // A channel arriving in the commit cycle is used straight from the bus.
  assign cmt_addr     = (wr_state_q == HAVE_AW) ? aw_addr_q : aw_addr_i;
  assign cmt_data     = (wr_state_q == HAVE_W)  ? w_data_q  : w_data_i;
  assign cmt_strb     = (wr_state_q == HAVE_W)  ? w_strb_q  : w_strb_i;
  assign cmt_in_range = in_range_f(cmt_addr);
  assign cmt_idx      = index_f(cmt_addr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= IDLE;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_resp_q   <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        IDLE: begin
          if (commit) begin
            wr_state_q <= RESP;
            b_resp_q   <= cmt_in_range ? RESP_OKAY : RESP_SLVERR;
          end else if (aw_hs) begin
            wr_state_q <= HAVE_AW;
            aw_addr_q  <= aw_addr_i;
          end else if (w_hs) begin
            wr_state_q <= HAVE_W;
            w_data_q   <= w_data_i;
            w_strb_q   <= w_strb_i;
          end
        end
        HAVE_AW, HAVE_W: begin
          if (commit) begin
            wr_state_q <= RESP;
            b_resp_q   <= cmt_in_range ? RESP_OKAY : RESP_SLVERR;
          end
        end
        RESP: begin
          if (b_ready_i) wr_state_q <= IDLE;
        end
        default: wr_state_q <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic                  sel;
      logic [DATA_WIDTH-1:0] reg_d;
      logic [DATA_WIDTH-1:0] reg_q;

      assign sel            = commit && cmt_in_range && (cmt_idx == IDX_W'(gi));
      assign wr_pulse_o[gi] = sel && (|cmt_strb);

      always_comb begin
        reg_d = reg_q;
        for (int b = 0; b < STRB_W; b++) begin
          if (sel && cmt_strb[b]) reg_d[b*8 +: 8] = cmt_data[b*8 +: 8];
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) reg_q <= RST_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
        else         reg_q <= reg_d;
      end

      assign reg_q_o[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
    end
  endgenerate

  assign ar_ready_o  = alive_q && !r_valid_q;
  assign ar_hs       = ar_valid_i && ar_ready_o;
  assign rd_in_range = in_range_f(ar_addr_i);
  assign rd_idx      = index_f(ar_addr_i);

  // Reads sample the register outputs, so a same-cycle commit is not yet visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      r_valid_q <= 1'b1;
      r_data_q  <= rd_in_range ? reg_q_o[rd_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
      r_resp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_ready_i) begin
      r_valid_q <= 1'b0;
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_data_o  = r_data_q;
  assign r_resp_o  = r_resp_q;

endmodule

// File: doc/axi_lite_regs.md
AXI_LITE_REGS -- requirements
Module: axi_lite_regs

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, the AXI-Lite address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the AXI-Lite data width; legal values 32 or 64.
REQ-003 The block SHALL have parameter NUM_REGS, default 8, the number of registers, at least 1.
REQ-004 The block SHALL have parameter BASE_ADDR, default 0, the byte address of register 0, aligned to DATA_WIDTH/8.
REQ-005 The block SHALL have parameter RST_VAL, default all zeros, NUM_REGS*DATA_WIDTH bits, with register k in slice k.
REQ-006 The block SHALL have these ports; the clock and reset are fixed as one clock, asynchronous active-low reset:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- aw_addr_i  in  ADDR_WIDTH  write address
- aw_valid_i / aw_ready_o  in/out  1  AW handshake
- w_data_i  in  DATA_WIDTH  write data
- w_strb_i  in  DATA_WIDTH/8  byte strobes
- w_valid_i / w_ready_o  in/out  1  W handshake
- b_resp_o  out  2  write response
- b_valid_o / b_ready_i  out/in  1  B handshake
- ar_addr_i  in  ADDR_WIDTH  read address
- ar_valid_i / ar_ready_o  in/out  1  AR handshake
- r_data_o  out  DATA_WIDTH  read data
- r_resp_o  out  2  read response
- r_valid_o / r_ready_i  out/in  1  R handshake
- reg_q_o  out  NUM_REGS*DATA_WIDTH  current register contents
- wr_pulse_o  out  NUM_REGS  one-cycle write indication per register

Function
REQ-007 The block SHALL compute the register index as (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); the low address bits are ignored.
REQ-008 The block SHALL treat an address below BASE_ADDR, or an index of NUM_REGS or more, as out of range.
REQ-009 The block SHALL accept AW and W independently, in either order or in the same cycle. Each channel is held in a one-entry latch until both are present.
REQ-010 aw_ready_o SHALL be high only when the AW latch is empty and b_valid_o is low. w_ready_o SHALL follow the same rule with the W latch.
REQ-011 In the cycle both latches are full and b_valid_o is low, the block SHALL commit the write:
- For an in-range index: update each byte whose strobe bit is set, and set b_resp_o=2'b00 (OKAY).
- For an out-of-range index: change no register, and set b_resp_o=2'b10 (SLVERR).
REQ-012 After a commit, the block SHALL assert b_valid_o on the next cycle, clear both latches, and hold b_valid_o and b_resp_o stable until b_ready_i.
REQ-013 Write FSM states SHALL be IDLE, HAVE_AW, HAVE_W, RESP:
- IDLE → HAVE_AW / HAVE_W on a single handshake.
- IDLE → RESP on a simultaneous AW and W handshake.
- HAVE_x → RESP when the other channel handshakes.
- RESP → IDLE on b_ready_i.
REQ-014 wr_pulse_o[k] SHALL be high for exactly the commit cycle when register k is in range and w_strb_i has at least one bit set.
REQ-015 ar_ready_o SHALL equal !r_valid_o. There is one outstanding read at most.
REQ-016 On an AR handshake, the block SHALL register the response for the next cycle:
- In range: r_data_o = the register value, r_resp_o=2'b00.
- Out of range: r_data_o=0, r_resp_o=2'b10.
REQ-017 The block SHALL hold r_valid_o, r_data_o and r_resp_o stable until r_ready_i.
REQ-018 When a read handshake and a write commit hit the same register in the same cycle, the read SHALL return the pre-write value.
REQ-019 reg_q_o SHALL reflect a committed write in the cycle after the commit.
REQ-020 The read and write paths SHALL be independent; neither stalls the other.

Reset
REQ-021 While rst_ni is low, the block SHALL asynchronously load every register from RST_VAL, empty both latches, enter write state IDLE, and drive all valid outputs, ready outputs and wr_pulse_o to 0.
REQ-022 A reset asserted mid-transaction SHALL drop the pending response; no partial write is committed.
REQ-023 In the first cycle after reset deassertion, aw_ready_o, w_ready_o and ar_ready_o SHALL be 1.

Verification
REQ-024 Write W before AW, with DW=32, BASE_ADDR=0, addr 0x8, data 0xDEADBEEF, strb 4'hF:
- b_valid_o rises one cycle after the AW handshake, with b_resp_o=00.
- wr_pulse_o[2] pulses once.
- A later read of 0x8 returns 0xDEADBEEF.
REQ-025 Partial strobe: register 1 = 0x11223344, then a write of 0xAABBCCDD with strb 4'b0101 → a read returns 0x11BB33DD.
REQ-026 Out-of-range access with NUM_REGS=8:
- A write to 0x20 → SLVERR, no wr_pulse_o, reg_q_o unchanged.
- A read of 0x20 → r_data_o=0, r_resp_o=10.
REQ-027 Backpressure: hold b_ready_i low for 5 cycles → b_valid_o stays high, aw_ready_o and w_ready_o stay 0, and a second write is accepted only after the B handshake.
REQ-028 Same cycle, read and write to register 3 (old value 0x5, new value 0x9) → read returns 0x5, and the next read returns 0x9.
REQ-029 Reset asserted while in state HAVE_AW → after deassertion all registers equal RST_VAL, no b_valid_o appears, and the ready outputs are 1.
